// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array readback path: FSM encoding,
// default geometry and the row width derived from it.
package sa_pkg;

    typedef enum logic [1:0] {
        RB_IDLE  = 2'd0,
        RB_ISSUE = 2'd1,
        RB_DRAIN = 2'd2,
        RB_DONE  = 2'd3
    } rb_state_t;

    localparam int NUM_COL_DEF              = 8;
    localparam int ACCU_DATA_WIDTH_DEF      = 32;
    localparam int LOG2_SRAM_BANK_DEPTH_DEF = 10;
    localparam int FIFO_DEPTH_DEF           = 4;
    localparam int ROW_W                    = NUM_COL_DEF * ACCU_DATA_WIDTH_DEF;

    // Occupancy counters need one extra bit so "full" is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sa_result_readback_if.sv
// Valid/ready row stream from the readback block to the host or DMA.
interface sa_result_readback_if
    import sa_pkg::*;
#(
    parameter int DATA_W = ROW_W
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sa_sync_fifo.sv
// Small first-word-fall-through FIFO; the head entry is visible on pop_data
// whenever count is non-zero.
module sa_sync_fifo
    import sa_pkg::*;
#(
    parameter int WIDTH = ROW_W,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_reg != FULL_CNT);
    assign do_pop  = pop && (count_reg != '0);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

endmodule

// File: rtl/sa_result_readback.sv
// Reads result rows from the down SRAM bank and streams them out, issuing
// reads only when the output buffer has room for the returning row.
module sa_result_readback
    import sa_pkg::*;
#(
    parameter int NUM_COL              = NUM_COL_DEF,
    parameter int ACCU_DATA_WIDTH      = ACCU_DATA_WIDTH_DEF,
    parameter int LOG2_SRAM_BANK_DEPTH = LOG2_SRAM_BANK_DEPTH_DEF,
    parameter int FIFO_DEPTH           = FIFO_DEPTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_rd_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH:0]       i_rd_num,
    input  logic                                i_sram_busy,
    output logic [NUM_COL-1:0]                  o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_down_rd_addr,
    input  logic [NUM_COL*ACCU_DATA_WIDTH-1:0]  i_down_rd_data,
    sa_result_readback_if.master                out_if,
    output logic                                o_busy,
    output logic                                o_done
);

    localparam int AW  = LOG2_SRAM_BANK_DEPTH;
    localparam int CW  = LOG2_SRAM_BANK_DEPTH + 1;
    localparam int RW  = NUM_COL * ACCU_DATA_WIDTH;
    localparam int FCW = cnt_width(FIFO_DEPTH);

    rb_state_t      state_reg;
    logic [AW-1:0]  addr_reg;
    logic [AW-1:0]  last_addr_reg;
    logic [CW-1:0]  num_reg;
    logic [CW-1:0]  issue_cnt_reg;
    logic [CW-1:0]  accept_cnt_reg;
    logic           inflight_reg;

    logic [FCW-1:0] fifo_count;
    logic [RW-1:0]  fifo_data;
    logic [AW-1:0]  cur_addr;
    logic           credit_ok;
    logic           issue;
    logic           pop;

    // A read is only launched if its row is guaranteed a FIFO slot on return.
    assign credit_ok = (FCW'(inflight_reg) + fifo_count) < FCW'(FIFO_DEPTH);
    assign issue     = (state_reg == RB_ISSUE) && !i_sram_busy
                       && (issue_cnt_reg < num_reg) && credit_ok;
    assign cur_addr  = addr_reg + issue_cnt_reg[AW-1:0];

    generate
        for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_rd_en
            assign o_down_rd_en[gi] = issue;
        end
    endgenerate

    assign o_down_rd_addr = issue ? cur_addr : last_addr_reg;

    assign out_if.valid = (fifo_count != '0);
    assign out_if.data  = fifo_data;
    assign pop          = out_if.valid && out_if.ready;

    assign o_busy = (state_reg != RB_IDLE);
    assign o_done = (state_reg == RB_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RB_IDLE;
            addr_reg       <= '0;
            last_addr_reg  <= '0;
            num_reg        <= '0;
            issue_cnt_reg  <= '0;
            accept_cnt_reg <= '0;
            inflight_reg   <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                issue_cnt_reg <= issue_cnt_reg + CW'(1);
                last_addr_reg <= cur_addr;
            end
            if (pop) begin
                accept_cnt_reg <= accept_cnt_reg + CW'(1);
            end
            case (state_reg)
                RB_IDLE: begin
                    if (i_start) begin
                        addr_reg       <= i_rd_start_addr;
                        num_reg        <= i_rd_num;
                        issue_cnt_reg  <= '0;
                        accept_cnt_reg <= '0;
                        state_reg      <= (i_rd_num != '0) ? RB_ISSUE : RB_DONE;
                    end
                end
                RB_ISSUE: begin
                    if (issue_cnt_reg == num_reg) begin
                        state_reg <= RB_DRAIN;
                    end
                end
                RB_DRAIN: begin
                    if (accept_cnt_reg == num_reg) begin
                        state_reg <= RB_DONE;
                    end
                end
                default: state_reg <= RB_IDLE;
            endcase
        end
    end

    sa_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data (i_down_rd_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count)
    );

endmodule
